// File: rtl/dff_resp_checker.sv
// Response checker for single-bit registered DUTs: predicts dut_q through a
// LAT-deep delay line of the stimulus and tallies mismatches over WINDOW samples.
module dff_resp_checker #(
  parameter int LAT    = 1,
  parameter int WINDOW = 20,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             di,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  localparam logic [3:0]       FILL_LAST = 4'(LAT - 1);
  localparam logic [CNT_W-1:0] SMP_LAST  = CNT_W'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [LAT-1:0]   dly;
  logic [3:0]       fill_cnt;
  logic             mismatch;
  logic             start_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // 4-state inequality so an X/Z on dut_q counts as a mismatch in simulation
  always_comb begin
    mismatch = (dut_q !== dly[LAT-1]);
    start_ok = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (fill_cnt == FILL_LAST) state_nxt = CHECK;
      CHECK:   if (sample_cnt == SMP_LAST) state_nxt = DONE;
      DONE:    if (start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FILL) || (state == CHECK);
    done = (state == DONE);
    pass = done && (err_cnt == '0);
  end

  // Delay line stage: dly[LAT-1] is di as sampled LAT edges ago
  always_ff @(posedge clk) begin
    if (rst) begin
      dly <= '0;
    end else begin
      dly[0] <= di;
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Compare stage: err_cnt never returns to zero once set, so it marks the first miss
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt   <= '0;
      err_cnt    <= '0;
      sample_cnt <= '0;
      first_err  <= '0;
    end else if (start_ok) begin
      fill_cnt   <= '0;
      err_cnt    <= '0;
      sample_cnt <= '0;
      first_err  <= '1;
    end else if (state == FILL) begin
      fill_cnt <= fill_cnt + 4'd1;
    end else if (state == CHECK) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        if (err_cnt == '0) first_err <= sample_cnt;
      end
    end
  end

endmodule
